registro_universal_param: RTL and testbench

REGISTRO_UNIVERSAL_PARAM -- requirements
Module: registro_universal_param

---
 rtl/registro_universal_param.sv | 98 +++++++++
 tb/tb_registro_universal_param.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/registro_universal_param.sv
// Universal shift register: shift left/right with serial fill, parallel load,
// and rotate, plus a full-cycle pulse after every WIDTH shift/rotate operations.
module registro_universal_param #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             ENB,
  input  logic [1:0]       MODO,
  input  logic             DIR,
  input  logic             S_IN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             S_OUT,
  output logic             RCO
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] MODO_SHL  = 2'b00;
  localparam logic [1:0] MODO_SHR  = 2'b01;
  localparam logic [1:0] MODO_LOAD = 2'b10;
  localparam logic [1:0] MODO_ROT  = 2'b11;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             s_out_nxt;
  logic             rco_nxt;
  logic             step_c;

  // Next-state logic; a disabled edge holds everything except RCO, which drops.
  always_comb begin
    q_nxt     = Q;
    s_out_nxt = S_OUT;
    cnt_nxt   = cnt;
    rco_nxt   = 1'b0;
    step_c    = 1'b0;
    if (ENB) begin
      unique case (MODO)
        MODO_SHL: begin
          q_nxt     = {Q[WIDTH-2:0], S_IN};
          s_out_nxt = Q[WIDTH-1];
          step_c    = 1'b1;
        end
        MODO_SHR: begin
          q_nxt     = {S_IN, Q[WIDTH-1:1]};
          s_out_nxt = Q[0];
          step_c    = 1'b1;
        end
        MODO_LOAD: begin
          q_nxt     = D;
          s_out_nxt = 1'b0;
          cnt_nxt   = '0;
        end
        MODO_ROT: begin
          if (DIR) begin
            q_nxt     = {Q[0], Q[WIDTH-1:1]};
            s_out_nxt = Q[0];
          end else begin
            q_nxt     = {Q[WIDTH-2:0], Q[WIDTH-1]};
            s_out_nxt = Q[WIDTH-1];
          end
          step_c = 1'b1;
        end
        default: begin
          q_nxt = Q;
        end
      endcase
      // Shifts and rotates of either direction share one operation count.
      if (step_c) begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          rco_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      Q     <= '0;
      S_OUT <= 1'b0;
      RCO   <= 1'b0;
      cnt   <= '0;
    end else begin
      Q     <= q_nxt;
      S_OUT <= s_out_nxt;
      RCO   <= rco_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_registro_universal_param.sv
// Self-checking bench for registro_universal_param (WIDTH=8) using a
// reference-model scoreboard plus fixed expected vectors.
module tb_registro_universal_param;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] q;
    logic         s;
    logic         r;
  } exp_t;

  logic         CLK;
  logic         RESET_L;
  logic         ENB;
  logic [1:0]   MODO;
  logic         DIR;
  logic         S_IN;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic         S_OUT;
  logic         RCO;

  exp_t sb[$];
  int   checks;
  int   errors;

  logic [W-1:0] mq;
  logic         ms;
  logic         mr;
  int           mcnt;

  registro_universal_param #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .ENB(ENB), .MODO(MODO), .DIR(DIR),
    .S_IN(S_IN), .D(D), .Q(Q), .S_OUT(S_OUT), .RCO(RCO)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Drive one edge, advance the reference model and queue its expectation.
  task automatic drive(input logic rst_l, input logic enb, input logic [1:0] modo,
                       input logic dir, input logic sin, input logic [W-1:0] d);
    logic [W-1:0] nq;
    logic         ns;
    RESET_L = rst_l; ENB = enb; MODO = modo; DIR = dir; S_IN = sin; D = d;
    if (!rst_l) begin
      mq = '0; ms = 1'b0; mr = 1'b0; mcnt = 0;
    end else if (!enb) begin
      mr = 1'b0;
    end else if (modo == 2'b10) begin
      mq = d; ms = 1'b0; mr = 1'b0; mcnt = 0;
    end else begin
      if (modo == 2'b00) begin
        ns = mq[W-1]; nq = (mq << 1) | W'(sin);
      end else if (modo == 2'b01) begin
        ns = mq[0];   nq = (mq >> 1) | (W'(sin) << (W - 1));
      end else if (!dir) begin
        ns = mq[W-1]; nq = (mq << 1) | W'(mq[W-1]);
      end else begin
        ns = mq[0];   nq = (mq >> 1) | (W'(mq[0]) << (W - 1));
      end
      mq = nq; ms = ns;
      if (mcnt == W - 1) begin
        mcnt = 0; mr = 1'b1;
      end else begin
        mcnt = mcnt + 1; mr = 1'b0;
      end
    end
    sb.push_back('{q: mq, s: ms, r: mr});
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 8'hA5);
    e = sb.pop_front();
    checks++;
    if ({Q, S_OUT, RCO} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got Q=%h S_OUT=%b RCO=%b, want Q=00 S_OUT=0 RCO=0", Q, S_OUT, RCO);
    end
    checks++;
    if ({Q, S_OUT, RCO} !== e) begin
      errors++;
      $display("FAIL reset_sb: got %h, want %h", {Q, S_OUT, RCO}, e);
    end
  endtask

  task automatic test_rotate_left();
    exp_t e;
    logic [W-1:0] tbl [8];
    tbl = '{8'h4B, 8'h96, 8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5};
    drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 8'hA5);
    e = sb.pop_front();
    checks++;
    if (Q !== 8'hA5 || RCO !== 1'b0) begin
      errors++;
      $display("FAIL rotl_load: got Q=%h RCO=%b, want Q=a5 RCO=0", Q, RCO);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 8'h00);
      e = sb.pop_front();
      checks++;
      if (Q !== tbl[i] || RCO !== (i == 7)) begin
        errors++;
        $display("FAIL rotl_%0d: got Q=%h RCO=%b, want Q=%h RCO=%b", i, Q, RCO, tbl[i], (i == 7));
      end
      checks++;
      if ({Q, S_OUT, RCO} !== e) begin
        errors++;
        $display("FAIL rotl_sb_%0d: got %h, want %h", i, {Q, S_OUT, RCO}, e);
      end
    end
  endtask

  task automatic test_shift();
    exp_t e;
    drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 8'h81);
    e = sb.pop_front();
    drive(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00);
    e = sb.pop_front();
    checks++;
    if (Q !== 8'h03 || S_OUT !== 1'b1) begin
      errors++;
      $display("FAIL shl: got Q=%h S_OUT=%b, want Q=03 S_OUT=1", Q, S_OUT);
    end
    drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
    e = sb.pop_front();
    checks++;
    if (Q !== 8'h01 || S_OUT !== 1'b1) begin
      errors++;
      $display("FAIL shr: got Q=%h S_OUT=%b, want Q=01 S_OUT=1", Q, S_OUT);
    end
    checks++;
    if ({Q, S_OUT, RCO} !== e) begin
      errors++;
      $display("FAIL shr_sb: got %h, want %h", {Q, S_OUT, RCO}, e);
    end
  endtask

  task automatic test_hold();
    exp_t e;
    logic [W-1:0] held;
    drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 8'h5A);
    e = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 8'h00);
      e = sb.pop_front();
    end
    held = Q;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 8'hFF);
      e = sb.pop_front();
      checks++;
      if (Q !== held || RCO !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: got Q=%h RCO=%b, want Q=%h RCO=0", i, Q, RCO, held);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 8'h00);
      e = sb.pop_front();
      checks++;
      if (RCO !== (i == 3) || (i == 3 && Q !== 8'h5A)) begin
        errors++;
        $display("FAIL hold_resume_%0d: got Q=%h RCO=%b, want RCO=%b", i, Q, RCO, (i == 3));
      end
    end
  endtask

  task automatic test_load_clears();
    exp_t e;
    drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 8'hF0);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 2'b00, 1'b0, 1'(i), 8'h00);
      e = sb.pop_front();
      checks++;
      if (RCO !== 1'b0) begin
        errors++;
        $display("FAIL ld_shift_%0d: got RCO=%b, want RCO=0", i, RCO);
      end
    end
    drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 8'h3C);
    e = sb.pop_front();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 8'h00);
      e = sb.pop_front();
      checks++;
      if (RCO !== (i == 7) || (i == 7 && Q !== 8'h3C)) begin
        errors++;
        $display("FAIL ld_rotr_%0d: got Q=%h RCO=%b, want RCO=%b", i, Q, RCO, (i == 7));
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int pulses;
    drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 8'hC3);
    e = sb.pop_front();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 8'h00);
      e = sb.pop_front();
    end
    drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h00);
    e = sb.pop_front();
    checks++;
    if (Q !== 8'h00 || RCO !== 1'b0 || S_OUT !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got Q=%h S_OUT=%b RCO=%b, want 00 0 0", Q, S_OUT, RCO);
    end
    drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 8'h96);
    e = sb.pop_front();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 8'h00);
      e = sb.pop_front();
      if (RCO === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || RCO !== 1'b1 || Q !== 8'h96) begin
      errors++;
      $display("FAIL rst_mid_pulses: got pulses=%0d RCO=%b Q=%h, want 1 1 96", pulses, RCO, Q);
    end
  endtask

  task automatic test_random();
    exp_t e;
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 40) != 0), ($urandom_range(0, 5) != 0),
            2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), W'($urandom));
      e = sb.pop_front();
      checks++;
      if ({Q, S_OUT, RCO} !== e) begin
        errors++;
        $display("FAIL random_%0d: got Q=%h S_OUT=%b RCO=%b, want Q=%h S_OUT=%b RCO=%b",
                 i, Q, S_OUT, RCO, e.q, e.s, e.r);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    mq = '0; ms = 1'b0; mr = 1'b0; mcnt = 0;
    RESET_L = 1'b0; ENB = 1'b0; MODO = 2'b00; DIR = 1'b0; S_IN = 1'b0; D = '0;
    test_reset();
    test_rotate_left();
    test_shift();
    test_hold();
    test_load_clears();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
